// File: rtl/mul_dispatch_32bit.sv
// mul_dispatch_32bit: queues tagged multiply requests in a small FIFO and
// dispatches them one at a time to an external multi-cycle multiplier,
// returning results in request order on a valid/ready response channel.
//
// Ports
//   clk, rst                 clock, asynchronous active-low reset
//   in_valid/in_ready        request handshake; in_a, in_b, in_tag payload
//   mul_req                  one-cycle start pulse to the multiplier
//   mul_a, mul_b             operands, held from issue until the ack
//   mul_out, mul_ack         multiplier result and its completion pulse
//   rsp_valid/rsp_ready      response handshake; rsp_data, rsp_tag payload
//   pending                  queued + in-flight + held-response count
module mul_dispatch_32bit #(
    parameter int unsigned width     = 32,
    parameter int unsigned depth     = 4,
    parameter int unsigned tag_width = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [width-1:0]           in_a,
    input  logic [width-1:0]           in_b,
    input  logic [tag_width-1:0]       in_tag,
    output logic                       mul_req,
    output logic [width-1:0]           mul_a,
    output logic [width-1:0]           mul_b,
    input  logic [width-1:0]           mul_out,
    input  logic                       mul_ack,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [width-1:0]           rsp_data,
    output logic [tag_width-1:0]       rsp_tag,
    output logic [$clog2(depth)+1:0]   pending
);

    localparam int unsigned AW = $clog2(depth);
    localparam int unsigned PW = AW + 2;
    localparam int unsigned EW = 2 * width + tag_width;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [AW:0]          wr_ptr_q, wr_ptr_d;
    logic [AW:0]          rd_ptr_q, rd_ptr_d;
    logic [EW-1:0]        mem_q [depth];
    logic                 mul_req_q, mul_req_d;
    logic [width-1:0]     mul_a_q, mul_a_d;
    logic [width-1:0]     mul_b_q, mul_b_d;
    logic [tag_width-1:0] tag_q, tag_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic [width-1:0]     rsp_data_q, rsp_data_d;
    logic [tag_width-1:0] rsp_tag_q, rsp_tag_d;
    logic [PW-1:0]        pending_q, pending_d;

    logic                 full;
    logic                 empty;
    logic                 push;
    logic [AW:0]          count_d;
    logic [width-1:0]     head_a;
    logic [width-1:0]     head_b;
    logic [tag_width-1:0] head_tag;

    // Extra pointer bit separates full from empty when the indices match.
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty = (wr_ptr_q == rd_ptr_q);
    // Acceptance looks only at registered state, so a full FIFO refuses even while popping.
    assign push  = in_valid && !full;
    assign {head_a, head_b, head_tag} = mem_q[rd_ptr_q[AW-1:0]];

    // Next-state and output logic.
    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        mul_req_d   = 1'b0;
        mul_a_d     = mul_a_q;
        mul_b_d     = mul_b_q;
        tag_d       = tag_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_tag_d   = rsp_tag_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        end

        if (rsp_valid_q && rsp_ready) begin
            rsp_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                // A held response blocks issue, so a result is never overwritten.
                if (!empty && !rsp_valid_q) begin
                    state_d   = ISSUE;
                    rd_ptr_d  = rd_ptr_q + (AW+1)'(1);
                    mul_req_d = 1'b1;
                    mul_a_d   = head_a;
                    mul_b_d   = head_b;
                    tag_d     = head_tag;
                end
            end
            ISSUE: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (mul_ack) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = mul_out;
                    rsp_tag_d   = tag_q;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        count_d   = wr_ptr_d - rd_ptr_d;
        pending_d = PW'(count_d) + PW'(state_d != IDLE) + PW'(rsp_valid_d);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            mul_req_q   <= 1'b0;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            tag_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_tag_q   <= '0;
            pending_q   <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            mul_req_q   <= mul_req_d;
            mul_a_q     <= mul_a_d;
            mul_b_q     <= mul_b_d;
            tag_q       <= tag_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_tag_q   <= rsp_tag_d;
            pending_q   <= pending_d;
        end
    end

    // FIFO storage; validity is tracked by the pointers, so no reset is needed.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= {in_a, in_b, in_tag};
        end
    end

    assign in_ready  = !full;
    assign mul_req   = mul_req_q;
    assign mul_a     = mul_a_q;
    assign mul_b     = mul_b_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_tag   = rsp_tag_q;
    assign pending   = pending_q;

endmodule

// File: tb/tb_mul_dispatch_32bit.sv
// Self-checking bench for mul_dispatch_32bit: a behavioural multiplier,
// a response sink with a request-order scoreboard, and directed plus
// randomized request sequences.
module tb_mul_dispatch_32bit;

    localparam int unsigned W  = 32;
    localparam int unsigned TW = 4;
    localparam int unsigned D  = 4;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_a;
    logic [W-1:0]  in_b;
    logic [TW-1:0] in_tag;
    logic          mul_req;
    logic [W-1:0]  mul_a;
    logic [W-1:0]  mul_b;
    logic [W-1:0]  mul_out;
    logic          mul_ack;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [W-1:0]  rsp_data;
    logic [TW-1:0] rsp_tag;
    logic [3:0]    pending;

    mul_dispatch_32bit #(.width(W), .depth(D), .tag_width(TW)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_a     (in_a),
        .in_b     (in_b),
        .in_tag   (in_tag),
        .mul_req  (mul_req),
        .mul_a    (mul_a),
        .mul_b    (mul_b),
        .mul_out  (mul_out),
        .mul_ack  (mul_ack),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_data (rsp_data),
        .rsp_tag  (rsp_tag),
        .pending  (pending)
    );

    int errors = 0;
    int checks = 0;

    // Expected responses in request order: {product[31:0], tag}.
    logic [W+TW-1:0] exp_q[$];
    int              n_rsp = 0;
    logic [W-1:0]    last_data;
    logic [TW-1:0]   last_tag;

    // Environment controls.
    bit ready_rand = 0;
    bit ready_fix  = 1;
    bit slow_mul   = 0;
    bit spur_go    = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] prod(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [63:0] p;
        p = 64'(a) * 64'(b);
        return p[W-1:0];
    endfunction

    // Present one request (called at a negedge); returns at the negedge after acceptance.
    task automatic push(input logic [W-1:0] a, input logic [W-1:0] b, input logic [TW-1:0] t);
        int n = 0;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_tag   = t;
        while (!in_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            chk("push_timeout", 64'(in_ready), 64'd1);
        end else begin
            exp_q.push_back({prod(a, b), t});
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((exp_q.size() != 0 || rsp_valid || pending != 4'd0) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("drain_left", 64'(exp_q.size()), 64'd0);
        chk("drain_pending", 64'(pending), 64'd0);
    endtask

    // Behavioural multiplier: latches operands on mul_req, acks after a random delay.
    initial begin : mul_model
        logic [W-1:0] ma, mb;
        int  cnt;
        bit  busy;
        bit  ack_chk;
        busy    = 0;
        ack_chk = 0;
        cnt     = 0;
        ma      = '0;
        mb      = '0;
        mul_ack = 1'b0;
        mul_out = '0;
        forever begin
            @(negedge clk);
            if (ack_chk) begin
                ack_chk = 0;
                if (rst) chk("rsp_after_ack", 64'(rsp_valid), 64'd1);
            end
            mul_ack = 1'b0;
            if (!rst) begin
                busy = 0;
            end else if (spur_go) begin
                spur_go = 0;
                mul_out = 32'd5;
                mul_ack = 1'b1;
            end else if (busy) begin
                chk("mul_a_stable", 64'(mul_a), 64'(ma));
                chk("mul_b_stable", 64'(mul_b), 64'(mb));
                chk("mul_req_one_cycle", 64'(mul_req), 64'd0);
                if (cnt == 0) begin
                    mul_out = prod(ma, mb);
                    mul_ack = 1'b1;
                    busy    = 0;
                    ack_chk = 1;
                end else begin
                    cnt--;
                end
            end else if (mul_req) begin
                busy = 1;
                ma   = mul_a;
                mb   = mul_b;
                cnt  = slow_mul ? 30 : int'($urandom_range(0, 3));
            end
        end
    end

    // Response sink and scoreboard; also checks a held response stays stable.
    initial begin : rsp_sink
        bit            hold_pend;
        logic [W-1:0]  hold_data;
        logic [TW-1:0] hold_tag;
        logic [W+TW-1:0] e;
        hold_pend = 0;
        hold_data = '0;
        hold_tag  = '0;
        rsp_ready = 1'b0;
        forever begin
            @(negedge clk);
            rsp_ready = ready_rand ? ($urandom_range(0, 1) == 1) : ready_fix;
            if (rst && rsp_valid) begin
                if (hold_pend) begin
                    chk("rsp_hold_data", 64'(rsp_data), 64'(hold_data));
                    chk("rsp_hold_tag", 64'(rsp_tag), 64'(hold_tag));
                end
                if (rsp_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("rsp_unexpected", 64'(rsp_valid), 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("rsp_data", 64'(rsp_data), 64'(e[W+TW-1:TW]));
                        chk("rsp_tag", 64'(rsp_tag), 64'(e[TW-1:0]));
                    end
                    n_rsp++;
                    last_data = rsp_data;
                    last_tag  = rsp_tag;
                    hold_pend = 0;
                end else begin
                    hold_pend = 1;
                    hold_data = rsp_data;
                    hold_tag  = rsp_tag;
                end
            end else begin
                hold_pend = 0;
            end
        end
    end

    initial begin : main
        int base;
        int n;
        bit saw;
        rst      = 1'b0;
        in_valid = 1'b0;
        in_a     = '0;
        in_b     = '0;
        in_tag   = '0;

        // Reset state.
        repeat (3) @(negedge clk);
        chk("rst_mul_req", 64'(mul_req), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_data", 64'(rsp_data), 64'd0);
        chk("rst_rsp_tag", 64'(rsp_tag), 64'd0);
        chk("rst_mul_a", 64'(mul_a), 64'd0);
        chk("rst_mul_b", 64'(mul_b), 64'd0);
        chk("rst_pending", 64'(pending), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Single request: 7*6 tag 3, mul_req on the second edge after presenting.
        ready_fix = 1;
        base = n_rsp;
        push(32'd7, 32'd6, 4'd3);
        chk("single_req_early", 64'(mul_req), 64'd0);
        chk("single_pending_q", 64'(pending), 64'd1);
        @(negedge clk);
        chk("single_req_high", 64'(mul_req), 64'd1);
        chk("single_mul_a", 64'(mul_a), 64'd7);
        chk("single_mul_b", 64'(mul_b), 64'd6);
        chk("single_pending_f", 64'(pending), 64'd1);
        @(negedge clk);
        chk("single_req_low", 64'(mul_req), 64'd0);
        wait_drain();
        chk("single_count", 64'(n_rsp - base), 64'd1);
        chk("single_data", 64'(last_data), 64'd42);
        chk("single_tag", 64'(last_tag), 64'd3);

        // Fill with the sink stalled: one issued plus a full FIFO.
        ready_fix = 0;
        base = n_rsp;
        for (int i = 0; i < 5; i++) push(32'(i + 1), 32'd3, 4'(i));
        chk("fill_in_ready", 64'(in_ready), 64'd0);
        chk("fill_pending", 64'(pending), 64'(D + 1));
        repeat (10) @(negedge clk);
        chk("fill_in_ready_hold", 64'(in_ready), 64'd0);
        chk("fill_pending_hold", 64'(pending), 64'(D + 1));
        chk("fill_rsp_valid", 64'(rsp_valid), 64'd1);
        ready_fix = 1;
        push(32'd6, 32'd3, 4'd5);
        wait_drain();
        chk("fill_count", 64'(n_rsp - base), 64'd6);

        // Ordering with a randomly stalling sink.
        ready_rand = 1;
        base = n_rsp;
        for (int t = 0; t < 4; t++) push(32'(t + 1), 32'd10, 4'(t));
        wait_drain();
        chk("order_count", 64'(n_rsp - base), 64'd4);
        chk("order_last_data", 64'(last_data), 64'd40);

        // Pointer wrap with truncated products.
        base = n_rsp;
        for (int i = 0; i < 3 * D; i++) push(32'hFFFF_FFFF, 32'd2, 4'(i));
        wait_drain();
        chk("wrap_count", 64'(n_rsp - base), 64'(3 * D));
        chk("wrap_last_data", 64'(last_data), 64'hFFFF_FFFE);

        // Random traffic.
        base = n_rsp;
        for (int i = 0; i < 40; i++) begin
            push($urandom, $urandom, 4'($urandom_range(0, 15)));
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 4)) @(negedge clk);
        end
        wait_drain();
        chk("rand_count", 64'(n_rsp - base), 64'd40);

        // Reset while waiting on the multiplier: the request must vanish.
        ready_rand = 0;
        ready_fix  = 1;
        slow_mul   = 1;
        push(32'd3, 32'd4, 4'd1);
        n = 0;
        while (!mul_req && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("rstw_saw_req", 64'(mul_req), 64'd1);
        repeat (2) @(negedge clk);
        #2;
        rst = 1'b0;
        exp_q.delete();
        #1;
        chk("rstw_async_pending", 64'(pending), 64'd0);
        chk("rstw_async_mul_a", 64'(mul_a), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        slow_mul = 0;
        saw = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (rsp_valid || mul_req) saw = 1;
        end
        chk("rstw_no_rsp", 64'(saw), 64'd0);
        chk("rstw_pending", 64'(pending), 64'd0);

        // Spurious ack while idle is ignored; a following request still works.
        spur_go = 1;
        saw = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (rsp_valid || mul_req || pending != 4'd0) saw = 1;
        end
        chk("spur_ignored", 64'(saw), 64'd0);
        base = n_rsp;
        push(32'd9, 32'd9, 4'd5);
        wait_drain();
        chk("spur_after_count", 64'(n_rsp - base), 64'd1);
        chk("spur_after_data", 64'(last_data), 64'd81);
        chk("spur_after_tag", 64'(last_tag), 64'd5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
